// File: rtl/add_num_pkg.sv
// add_num_pkg: shared types for the add-two-numbers job sequencer.
// FSM states, FIFO result record, byte-lane positions.
package add_num_pkg;

  localparam int ANS_IDX_W = 16;
  localparam int SUM_W     = 9;
  localparam int OPA_LSB   = 8;
  localparam int OPB_LSB   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } t_ans_state;

  typedef struct packed {
    logic [ANS_IDX_W-1:0] idx;
    logic [SUM_W-1:0]     sum;
  } t_ans_result;

  function automatic logic [SUM_W-1:0] add_bytes(
    input logic [7:0] a,
    input logic [7:0] b
  );
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/add_num_result_fifo.sv
// add_num_result_fifo: sync FIFO of per-line results.
// Depth is a power of two; pointers carry one wrap bit.
module add_num_result_fifo
  import add_num_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        push_i,
  input  t_ans_result din_i,
  input  logic        pop_i,
  output t_ans_result dout_o,
  output logic        empty_o,
  output logic        full_o
);
  localparam int AW = $clog2(DEPTH);

  t_ans_result    mem_q [DEPTH];
  logic [AW:0]    wp_q;
  logic [AW:0]    rp_q;

  assign empty_o = (wp_q == rp_q);
  assign full_o  = (wp_q[AW] != rp_q[AW]) &&
                   (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign dout_o  = mem_q[rp_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wp_q[AW-1:0]] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (push_i) wp_q <= wp_q + 1'b1;
      if (pop_i)  rp_q <= rp_q + 1'b1;
    end
  end

  // The outstanding-read cap must keep this from ever overflowing.
  always_ff @(posedge clk) begin
    if (reset_n) assert (!(push_i && full_o && !pop_i));
  end

endmodule

// File: rtl/add_num_job_sched.sv
// add_num_job_sched: batch of byte-add jobs over CCI-P c0/c1.
// Reads src lines, adds bytes 1+2, writes 9-bit sums to dst lines.
module add_num_job_sched
  import add_num_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 8,
  parameter int IDX_W           = ANS_IDX_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [41:0]      src_addr,
  input  logic [41:0]      dst_addr,
  input  logic [IDX_W-1:0] num_lines,
  output logic             busy,
  output logic             done,
  output logic             c0_req_valid,
  output logic [41:0]      c0_req_addr,
  output logic [15:0]      c0_req_mdata,
  input  logic             c0_almfull,
  input  logic             c0_rsp_valid,
  input  logic [15:0]      c0_rsp_mdata,
  input  logic [511:0]     c0_rsp_data,
  output logic             c1_req_valid,
  output logic [41:0]      c1_req_addr,
  output logic [511:0]     c1_req_data,
  input  logic             c1_almfull,
  input  logic             c1_rsp_valid
);
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

  t_ans_state       state_q;
  logic [41:0]      src_q, dst_q;
  logic [IDX_W-1:0] num_q, rd_idx_q, wr_ack_q;
  logic [OW-1:0]    out_q;
  logic             busy_q, done_q;
  logic             c0_vld_q, c1_vld_q;
  logic [41:0]      c0_addr_q, c1_addr_q;
  logic [15:0]      c0_mdata_q;
  logic [SUM_W-1:0] c1_sum_q;

  logic        active, issue, push, pop;
  logic        fifo_empty, fifo_full;
  t_ans_result rsp_res, head_res;
  logic        unused_ok;

  assign active = (state_q == RUN) || (state_q == DRAIN);
  assign issue  = (state_q == RUN) && !c0_almfull &&
                  (rd_idx_q < num_q) &&
                  (out_q < OW'(MAX_OUTSTANDING));
  assign push   = active && c0_rsp_valid;
  assign pop    = active && !fifo_empty && !c1_almfull;

  assign rsp_res.idx = ANS_IDX_W'(c0_rsp_mdata[IDX_W-1:0]);
  assign rsp_res.sum = add_bytes(c0_rsp_data[OPA_LSB +: 8],
                                 c0_rsp_data[OPB_LSB +: 8]);

  assign unused_ok = ^{c0_rsp_data[511:24],
                       c0_rsp_data[7:0], fifo_full};

  add_num_result_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push_i (push),
    .din_i  (rsp_res),
    .pop_i  (pop),
    .dout_o (head_res),
    .empty_o(fifo_empty),
    .full_o (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      c0_vld_q <= 1'b0;
      c1_vld_q <= 1'b0;
      rd_idx_q <= '0;
      wr_ack_q <= '0;
      out_q    <= '0;
    end else begin
      c0_vld_q <= issue;
      c1_vld_q <= pop;
      done_q   <= (state_q == DONE);
      if (issue) begin
        c0_addr_q  <= src_q + 42'(rd_idx_q);
        c0_mdata_q <= 16'(rd_idx_q);
      end
      if (pop) begin
        c1_addr_q <= dst_q + 42'(head_res.idx);
        c1_sum_q  <= head_res.sum;
      end
      rd_idx_q <= rd_idx_q + IDX_W'(issue);
      out_q    <= out_q + OW'(issue) - OW'(pop);
      wr_ack_q <= wr_ack_q + IDX_W'(active && c1_rsp_valid);
      unique case (state_q)
        IDLE: begin
          if (start) begin
            src_q    <= src_addr;
            dst_q    <= dst_addr;
            num_q    <= num_lines;
            rd_idx_q <= '0;
            wr_ack_q <= '0;
            out_q    <= '0;
            busy_q   <= (num_lines != '0);
            state_q  <= (num_lines == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (rd_idx_q == num_q) state_q <= DRAIN;
        end
        DRAIN: begin
          if (wr_ack_q == num_q) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
          end
        end
        DONE: state_q <= IDLE;
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign c0_req_valid = c0_vld_q;
  assign c0_req_addr  = c0_addr_q;
  assign c0_req_mdata = c0_mdata_q;
  assign c1_req_valid = c1_vld_q;
  assign c1_req_addr  = c1_addr_q;
  assign c1_req_data  = {503'b0, c1_sum_q};

endmodule
